spi_slave_core: RTL and testbench

SPI slave-side shift engine, the far end of the link driven by the master's baud-rate/SCLK generator. Synchronises the incoming SCLK, SS and MOSI into the PCLK domain, detects SCLK edges according to CPOL/CPHA, and assembles received frames from MOSI. Concurrently it shifts a preloaded transmit word out on MISO. It sits between the SPI pins and the slave's APB register block, which supplies mode bits and exchanges data words via simple valid/ready flags.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_sync.sv | 24 ++
 rtl/spi_slave_core.sv | 170 +++++++++++++++++
 tb/tb_spi_slave_core.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Types and constants shared by the SPI slave shift engine and its synchronisers.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // SPI mode number encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
        return {cpol, cpha};
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage flip-flop synchroniser for one asynchronous SPI pin.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave shift engine: synchronises SCLK/SS/MOSI into PCLK, receives frames from
// MOSI and shifts the preloaded transmit word out on MISO.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int  DATA_W      = SPI_DATA_W,
    parameter int  SYNC_STAGES = 2,
    localparam int CNT_W       = $clog2(DATA_W + 1)
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              spe,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfe,
    input  logic              sclk_in,
    input  logic              ss_in,
    input  logic              mosi_in,
    output logic              miso_out,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_full,
    input  logic              rx_read,
    output logic              overrun,
    output spi_state_e        state_dbg,
    output logic [CNT_W-1:0]  bit_cnt_dbg
);

    spi_state_e        state, state_next;
    logic              cpol_q, cpha_q, lsbfe_q;
    logic              sclk_n, ss_s, mosi_s, sclk_prev, ss_prev;
    logic              lead, trail, sample_edge, shift_edge, ss_fall, ss_rise;
    logic              go_idle, start, do_sample, do_shift, frame_done;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_sr, rx_next, tx_sr, tx_buf, tx_word;

    // SCLK is normalised against the latched cpol so the synchroniser idles at 0
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(PCLK), .rst_n(PRESETn), .d(sclk_in ^ cpol_q), .q(sclk_n));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(PCLK), .rst_n(PRESETn), .d(ss_in), .q(ss_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(PCLK), .rst_n(PRESETn), .d(mosi_in), .q(mosi_s));

    assign lead        = sclk_n & ~sclk_prev;
    assign trail       = ~sclk_n & sclk_prev;
    assign sample_edge = cpha_q ? trail : lead;
    assign shift_edge  = cpha_q ? lead : trail;
    assign ss_fall     = ss_prev & ~ss_s;
    assign ss_rise     = ~ss_prev & ss_s;

    assign rx_next = lsbfe_q ? {mosi_s, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], mosi_s};
    assign tx_word = tx_ready ? '0 : tx_buf;

    always_comb begin
        state_next = state;
        go_idle    = 1'b0;
        start      = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (spe && ss_fall) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (!spe || ss_rise) begin
                    state_next = IDLE;
                    go_idle    = 1'b1;
                end else begin
                    do_sample  = sample_edge;
                    // cpha=0: the trailing edge right after a frame's last sample holds MISO
                    do_shift   = shift_edge && (cpha_q || bit_cnt != '0);
                    frame_done = sample_edge && (bit_cnt == CNT_W'(DATA_W - 1));
                    start      = frame_done;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsbfe_q   <= 1'b0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
        end else begin
            state     <= state_next;
            sclk_prev <= sclk_n;
            ss_prev   <= ss_s;
            if (state == IDLE) begin
                cpol_q  <= cpol;
                cpha_q  <= cpha;
                lsbfe_q <= lsbfe;
            end
            if (state == IDLE || go_idle || frame_done) begin
                bit_cnt <= '0;
            end else if (do_sample) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (do_sample) begin
                rx_sr <= rx_next;
            end
        end
    end

    // A read in the same cycle as a completion frees the slot for the new frame
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_data <= '0;
            rx_full <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (rx_read) begin
                rx_full <= 1'b0;
                overrun <= 1'b0;
            end
            if (frame_done) begin
                if (!rx_full || rx_read) begin
                    rx_data <= rx_next;
                    rx_full <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            miso_out <= 1'b0;
            tx_sr    <= '0;
            tx_buf   <= '0;
            tx_ready <= 1'b1;
        end else begin
            if (start) begin
                tx_ready <= 1'b1;
                if (!cpha_q) begin
                    miso_out <= lsbfe_q ? tx_word[0] : tx_word[DATA_W-1];
                    tx_sr    <= lsbfe_q ? (tx_word >> 1) : (tx_word << 1);
                end else begin
                    tx_sr <= tx_word;
                end
            end else if (do_shift) begin
                miso_out <= lsbfe_q ? tx_sr[0] : tx_sr[DATA_W-1];
                tx_sr    <= lsbfe_q ? (tx_sr >> 1) : (tx_sr << 1);
            end
            if (tx_load && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

    assign miso_oe     = (state == ACTIVE);
    assign state_dbg   = state;
    assign bit_cnt_dbg = bit_cnt;

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: a bit-banged SPI master plus an rx scoreboard.
module tb_spi_slave_core;
    import spi_pkg::*;

    localparam int W    = 8;
    localparam int HALF = 8;

    logic         PCLK = 1'b0;
    logic         PRESETn = 1'b0;
    logic         spe = 1'b0, cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
    logic         sclk_in = 1'b0, ss_in = 1'b1, mosi_in = 1'b0;
    logic         miso_out, miso_oe, tx_ready, rx_full, overrun;
    logic [W-1:0] tx_data = '0;
    logic         tx_load = 1'b0, rx_read = 1'b0;
    logic [W-1:0] rx_data;
    spi_state_e   state_dbg;
    logic [3:0]   bit_cnt_dbg;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic         rx_full_q = 1'b0;
    logic [W-1:0] mi, mi2;

    spi_slave_core #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .spe(spe), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
        .sclk_in(sclk_in), .ss_in(ss_in), .mosi_in(mosi_in), .miso_out(miso_out),
        .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_full(rx_full), .rx_read(rx_read), .overrun(overrun),
        .state_dbg(state_dbg), .bit_cnt_dbg(bit_cnt_dbg));

    // clock / reset
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every new rx_full rise must match the oldest expected frame
    always @(negedge PCLK) begin
        if (rx_full && !rx_full_q) begin
            if (exp_q.size() == 0) chk("sb_pending", 32'(exp_q.size()), 32'd1);
            else chk("sb_rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        rx_full_q <= rx_full;
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic set_mode(input logic p, input logic h, input logic l);
        cpol = p; cpha = h; lsbfe = l; sclk_in = p;
        cyc(6);
    endtask

    task automatic load_tx(input logic [W-1:0] d);
        tx_data = d; tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
    endtask

    task automatic read_rx();
        rx_read = 1'b1;
        cyc(1);
        rx_read = 1'b0;
        cyc(1);
    endtask

    task automatic ss_low();
        ss_in = 1'b0;
        cyc(HALF);
    endtask

    task automatic ss_high();
        ss_in = 1'b1;
        cyc(HALF);
    endtask

    task automatic xfer(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi_o);
        int idx;
        mi_o = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsbfe ? i : W - 1 - i;
            if (!cpha) begin
                mosi_in = mo[idx];
                cyc(HALF);
                sclk_in = ~cpol;
                mi_o[idx] = miso_out;
                cyc(HALF);
                sclk_in = cpol;
            end else begin
                cyc(HALF);
                sclk_in = ~cpol;
                mosi_in = mo[idx];
                cyc(HALF);
                sclk_in = cpol;
                mi_o[idx] = miso_out;
            end
        end
        cyc(HALF);
    endtask

    initial begin
        cyc(3);
        chk("rst_miso_out", 32'(miso_out), 32'd0);
        chk("rst_miso_oe", 32'(miso_oe), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_full", 32'(rx_full), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        chk("rst_bit_cnt", 32'(bit_cnt_dbg), 32'd0);
        PRESETn = 1'b1;
        spe = 1'b1;
        cyc(4);

        // mode 0, MSB first
        set_mode(1'b0, 1'b0, 1'b0);
        load_tx(8'h3C);
        chk("m0_tx_ready_loaded", 32'(tx_ready), 32'd0);
        exp_q.push_back(8'hA5);
        ss_low();
        chk("m0_tx_ready_start", 32'(tx_ready), 32'd1);
        chk("m0_miso_oe", 32'(miso_oe), 32'd1);
        xfer(8'hA5, 8, mi);
        chk("m0_rx_full", 32'(rx_full), 32'd1);
        chk("m0_miso_word", 32'(mi), 32'h3C);
        ss_high();
        chk("m0_oe_off", 32'(miso_oe), 32'd0);
        read_rx();
        chk("m0_read_clr", 32'(rx_full), 32'd0);

        // mode 3, LSB first, empty tx buffer
        set_mode(1'b1, 1'b1, 1'b1);
        exp_q.push_back(8'h81);
        ss_low();
        xfer(8'h81, 8, mi);
        chk("m3_rx_data", 32'(rx_data), 32'h81);
        chk("m3_miso_word", 32'(mi), 32'h00);
        ss_high();
        read_rx();

        // back-to-back frames without a read, second tx word loaded mid-frame
        set_mode(1'b0, 1'b0, 1'b0);
        load_tx(8'h96);
        ss_low();
        load_tx(8'h69);
        load_tx(8'hFF);
        chk("b2b_tx_ready", 32'(tx_ready), 32'd0);
        exp_q.push_back(8'h11);
        xfer(8'h11, 8, mi);
        xfer(8'h22, 8, mi2);
        ss_high();
        chk("b2b_miso1", 32'(mi), 32'h96);
        chk("b2b_miso2", 32'(mi2), 32'h69);
        chk("b2b_rx_data", 32'(rx_data), 32'h11);
        chk("b2b_rx_full", 32'(rx_full), 32'd1);
        chk("b2b_overrun", 32'(overrun), 32'd1);
        read_rx();
        chk("b2b_full_clr", 32'(rx_full), 32'd0);
        chk("b2b_ovr_clr", 32'(overrun), 32'd0);

        // abort after 5 bits, then a clean frame
        ss_low();
        xfer(8'hC3, 5, mi);
        ss_high();
        chk("abort_rx_full", 32'(rx_full), 32'd0);
        chk("abort_bit_cnt", 32'(bit_cnt_dbg), 32'd0);
        chk("abort_state", 32'(state_dbg), 32'(IDLE));
        exp_q.push_back(8'h5A);
        ss_low();
        xfer(8'h5A, 8, mi);
        ss_high();
        chk("abort_next_full", 32'(rx_full), 32'd1);

        // reset mid-frame in mode 1 (rx_full and rx_data still hold 8'h5A)
        set_mode(1'b0, 1'b1, 1'b0);
        load_tx(8'hFF);
        ss_low();
        load_tx(8'hAA);
        xfer(8'h0F, 3, mi);
        chk("m1_pre_miso", 32'(miso_out), 32'd1);
        PRESETn = 1'b0;
        #1;
        chk("mrst_miso_out", 32'(miso_out), 32'd0);
        chk("mrst_miso_oe", 32'(miso_oe), 32'd0);
        chk("mrst_tx_ready", 32'(tx_ready), 32'd1);
        chk("mrst_rx_data", 32'(rx_data), 32'd0);
        chk("mrst_rx_full", 32'(rx_full), 32'd0);
        chk("mrst_overrun", 32'(overrun), 32'd0);
        chk("mrst_bit_cnt", 32'(bit_cnt_dbg), 32'd0);
        ss_in = 1'b1;
        sclk_in = cpol;
        cyc(2);
        PRESETn = 1'b1;
        cyc(6);
        exp_q.push_back(8'hF0);
        ss_low();
        xfer(8'hF0, 8, mi);
        ss_high();
        chk("m1_rx_full", 32'(rx_full), 32'd1);

        cyc(4);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
